// File: rtl/truth_table_lut_seq.sv
// Registered multi-channel truth-table evaluator with a double-buffered
// table (shadow for writes, active for lookup) and atomic commit.
module truth_table_lut_seq #(
    parameter int N_IN = 3,
    parameter int N_CH = 1,
    parameter int CNT_W = 8,
    parameter logic [N_CH*(2**N_IN)-1:0] INIT = 8'hAC
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             in_valid,
    input  logic [N_IN-1:0]  x,
    input  logic             cfg_we,
    input  logic [N_IN-1:0]  cfg_addr,
    input  logic [N_CH-1:0]  cfg_data,
    input  logic             cfg_commit,
    output logic             out_valid,
    output logic [N_CH-1:0]  f,
    output logic [CNT_W-1:0] eval_cnt,
    output logic             dirty
);

    localparam int DEPTH = 2 ** N_IN;
    localparam int TW = N_CH * DEPTH;

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    state_t state_q, state_d;

    logic [TW-1:0]    act_q;
    logic [TW-1:0]    shd_q;
    logic [TW-1:0]    shd_nxt;
    logic [N_CH-1:0]  lut;
    logic [CNT_W-1:0] cnt_max;

    assign cnt_max = '1;

    // Shadow image with this cycle's write merged in; a commit in the
    // same cycle copies this image so the write is not lost.
    always_comb begin
        shd_nxt = shd_q;
        if (cfg_we) begin
            for (int c = 0; c < N_CH; c++) begin
                shd_nxt[c*DEPTH + int'(cfg_addr)] = cfg_data[c];
            end
        end
    end

    always_comb begin
        lut = '0;
        for (int c = 0; c < N_CH; c++) begin
            lut[c] = act_q[c*DEPTH + int'(x)];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cfg_we && !cfg_commit) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (cfg_commit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dirty = (state_q == PENDING);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            act_q   <= INIT;
            shd_q   <= INIT;
        end else begin
            state_q <= state_d;
            shd_q   <= shd_nxt;
            if (cfg_commit) begin
                act_q <= shd_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid <= 1'b0;
            f         <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                f <= lut;
            end
        end
    end

    // Clear on commit wins, then a same-cycle evaluation still counts.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            eval_cnt <= '0;
        end else if (cfg_commit) begin
            eval_cnt <= in_valid ? CNT_W'(1) : '0;
        end else if (in_valid && eval_cnt != cnt_max) begin
            eval_cnt <= eval_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_truth_table_lut_seq.sv
// Directed bench for truth_table_lut_seq: default, narrow-counter and
// 4-input/2-channel instances.
module tb_truth_table_lut_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instances A (default) and B (CNT_W=4) share stimulus.
    logic       arn = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] x = '0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_addr = '0;
    logic [0:0] cfg_data = '0;
    logic       cfg_commit = 1'b0;

    logic       a_ov, b_ov, a_dirty, b_dirty;
    logic [0:0] a_f, b_f;
    logic [7:0] a_cnt;
    logic [3:0] b_cnt;

    // Instance C: N_IN=4, N_CH=2.
    logic       arn2 = 1'b0;
    logic       iv2 = 1'b0;
    logic [3:0] x2 = '0;
    logic       we2 = 1'b0;
    logic [3:0] addr2 = '0;
    logic [1:0] data2 = '0;
    logic       cm2 = 1'b0;
    logic       c_ov, c_dirty;
    logic [1:0] c_f;
    logic [7:0] c_cnt;

    truth_table_lut_seq u_a (
        .clk(clk), .aresetn(arn), .in_valid(in_valid), .x(x),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_commit(cfg_commit), .out_valid(a_ov), .f(a_f),
        .eval_cnt(a_cnt), .dirty(a_dirty)
    );

    truth_table_lut_seq #(.CNT_W(4)) u_b (
        .clk(clk), .aresetn(arn), .in_valid(in_valid), .x(x),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_commit(cfg_commit), .out_valid(b_ov), .f(b_f),
        .eval_cnt(b_cnt), .dirty(b_dirty)
    );

    truth_table_lut_seq #(
        .N_IN(4), .N_CH(2), .INIT(32'hF00F_5A3C)
    ) u_c (
        .clk(clk), .aresetn(arn2), .in_valid(iv2), .x(x2),
        .cfg_we(we2), .cfg_addr(addr2), .cfg_data(data2),
        .cfg_commit(cm2), .out_valid(c_ov), .f(c_f),
        .eval_cnt(c_cnt), .dirty(c_dirty)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        arn = 1'b0;
        arn2 = 1'b0;
        repeat (2) tick();
        checks++;
        if (a_ov !== 1'b0 || a_f !== 1'b0) begin
            errors++;
            $display("FAIL reset_out ov=%b f=%b want 0 0", a_ov, a_f);
        end
        checks++;
        if (a_cnt !== 8'd0 || a_dirty !== 1'b0) begin
            errors++;
            $display("FAIL reset_state cnt=%0d dirty=%b want 0 0",
                     a_cnt, a_dirty);
        end
        checks++;
        if (c_ov !== 1'b0 || c_f !== 2'b00 || c_dirty !== 1'b0) begin
            errors++;
            $display("FAIL reset_c ov=%b f=%b dirty=%b want 0 00 0",
                     c_ov, c_f, c_dirty);
        end
        arn = 1'b1;
        arn2 = 1'b1;
        tick();
    endtask

    task automatic test_sweep();
        logic [7:0] exp_t;
        exp_t = 8'hAC;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            x = 3'(i);
            tick();
            checks++;
            if (a_ov !== 1'b1 || a_f[0] !== exp_t[i]) begin
                errors++;
                $display("FAIL sweep x=%0d ov=%b f=%b want 1 %b",
                         i, a_ov, a_f, exp_t[i]);
            end
        end
        in_valid = 1'b0;
        x = 3'd0;
        tick();
        checks++;
        if (a_ov !== 1'b0 || a_f !== 1'b1) begin
            errors++;
            $display("FAIL hold ov=%b f=%b want 0 1", a_ov, a_f);
        end
        checks++;
        if (a_cnt !== 8'd8) begin
            errors++;
            $display("FAIL count8 cnt=%0d want 8", a_cnt);
        end
    endtask

    task automatic test_shadow();
        cfg_we = 1'b1;
        cfg_addr = 3'd0;
        cfg_data = 1'b1;
        tick();
        cfg_we = 1'b0;
        checks++;
        if (a_dirty !== 1'b1) begin
            errors++;
            $display("FAIL dirty_set dirty=%b want 1", a_dirty);
        end
        in_valid = 1'b1;
        x = 3'd0;
        tick();
        in_valid = 1'b0;
        checks++;
        if (a_f !== 1'b0 || a_dirty !== 1'b1) begin
            errors++;
            $display("FAIL shadow_isol f=%b dirty=%b want 0 1",
                     a_f, a_dirty);
        end
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        checks++;
        if (a_dirty !== 1'b0 || a_cnt !== 8'd0) begin
            errors++;
            $display("FAIL commit dirty=%b cnt=%0d want 0 0",
                     a_dirty, a_cnt);
        end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (a_f !== 1'b1 || a_cnt !== 8'd1) begin
            errors++;
            $display("FAIL post_commit f=%b cnt=%0d want 1 1", a_f, a_cnt);
        end
    endtask

    task automatic test_commit_and_eval();
        // Restore ACT[0]=0, then stage SHD[0]=1.
        cfg_we = 1'b1;
        cfg_addr = 3'd0;
        cfg_data = 1'b0;
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        cfg_data = 1'b1;
        tick();
        cfg_we = 1'b0;
        checks++;
        if (a_dirty !== 1'b1) begin
            errors++;
            $display("FAIL restage dirty=%b want 1", a_dirty);
        end
        cfg_commit = 1'b1;
        in_valid = 1'b1;
        x = 3'd0;
        tick();
        cfg_commit = 1'b0;
        checks++;
        if (a_f !== 1'b0 || a_cnt !== 8'd1 || a_dirty !== 1'b0) begin
            errors++;
            $display("FAIL same_edge f=%b cnt=%0d dirty=%b want 0 1 0",
                     a_f, a_cnt, a_dirty);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (a_f !== 1'b1 || a_cnt !== 8'd2) begin
            errors++;
            $display("FAIL after_same f=%b cnt=%0d want 1 2", a_f, a_cnt);
        end
    endtask

    task automatic test_merge();
        cfg_we = 1'b1;
        cfg_addr = 3'd7;
        cfg_data = 1'b0;
        cfg_commit = 1'b1;
        tick();
        cfg_we = 1'b0;
        cfg_commit = 1'b0;
        checks++;
        if (a_dirty !== 1'b0) begin
            errors++;
            $display("FAIL merge_dirty dirty=%b want 0", a_dirty);
        end
        in_valid = 1'b1;
        x = 3'd7;
        tick();
        checks++;
        if (a_f !== 1'b0) begin
            errors++;
            $display("FAIL merge_x7 f=%b want 0", a_f);
        end
        x = 3'd5;
        tick();
        in_valid = 1'b0;
        checks++;
        if (a_f !== 1'b1) begin
            errors++;
            $display("FAIL merge_x5 f=%b want 1", a_f);
        end
    endtask

    task automatic test_saturate();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            in_valid = 1'b1;
            x = 3'(i);
            tick();
            if (i == 14 || i == 15 || i == 20) begin
                checks++;
                if (b_cnt !== 4'((i > 15) ? 15 : i)) begin
                    errors++;
                    $display("FAIL sat_cnt i=%0d cnt=%0d want %0d",
                             i, b_cnt, (i > 15) ? 15 : i);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (a_cnt !== 8'd20) begin
            errors++;
            $display("FAIL wide_cnt cnt=%0d want 20", a_cnt);
        end
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        checks++;
        if (b_cnt !== 4'd0) begin
            errors++;
            $display("FAIL sat_clear cnt=%0d want 0", b_cnt);
        end
    endtask

    task automatic test_wide();
        logic [3:0] xs [4];
        logic [1:0] fs [4];
        xs = '{4'd9, 4'd0, 4'd15, 4'd4};
        fs = '{2'b01, 2'b10, 2'b10, 2'b01};
        for (int i = 0; i < 4; i++) begin
            iv2 = 1'b1;
            x2 = xs[i];
            tick();
            checks++;
            if (c_f !== fs[i]) begin
                errors++;
                $display("FAIL wide_init x=%0d f=%b want %b",
                         xs[i], c_f, fs[i]);
            end
        end
        iv2 = 1'b0;
        we2 = 1'b1;
        addr2 = 4'd9;
        data2 = 2'b10;
        tick();
        we2 = 1'b0;
        cm2 = 1'b1;
        tick();
        cm2 = 1'b0;
        iv2 = 1'b1;
        x2 = 4'd9;
        tick();
        checks++;
        if (c_f !== 2'b10 || c_ov !== 1'b1) begin
            errors++;
            $display("FAIL wide_write f=%b ov=%b want 10 1", c_f, c_ov);
        end
        we2 = 1'b1;
        addr2 = 4'd0;
        data2 = 2'b01;
        tick();
        we2 = 1'b0;
        arn2 = 1'b0;
        #1;
        checks++;
        if (c_ov !== 1'b0 || c_f !== 2'b00 || c_dirty !== 1'b0) begin
            errors++;
            $display("FAIL async_rst ov=%b f=%b dirty=%b want 0 00 0",
                     c_ov, c_f, c_dirty);
        end
        tick();
        arn2 = 1'b1;
        tick();
        tick();
        checks++;
        if (c_f !== 2'b01) begin
            errors++;
            $display("FAIL rst_table x=9 f=%b want 01", c_f);
        end
        x2 = 4'd0;
        tick();
        iv2 = 1'b0;
        checks++;
        if (c_f !== 2'b10 || c_dirty !== 1'b0) begin
            errors++;
            $display("FAIL rst_shadow x=0 f=%b dirty=%b want 10 0",
                     c_f, c_dirty);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_shadow();
        test_commit_and_eval();
        test_merge();
        test_saturate();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
